// File: rtl/fx_issue_scheduler_if.sv
// Instruction, writeback and issue signal bundle for fx_issue_scheduler.
// The decode/writeback side uses the master modport; the scheduler uses slave.
interface fx_issue_scheduler_if #(
  parameter int opcodeWidth      = 6,
  parameter int xOpCodeWidth     = 10,
  parameter int immWith          = 16,
  parameter int regWidth         = 5,
  parameter int formatIndexRange = 5,
  parameter int queueDepth       = 4,
  parameter int stallCntWidth    = 16
);
  localparam int OccWidth = $clog2(queueDepth) + 1;

  logic                        enable_i;
  logic                        flush_i;
  logic                        instValid_i;
  logic                        instReady_o;
  logic [opcodeWidth-1:0]      opCode_i;
  logic [xOpCodeWidth-1:0]     xOpCode_i;
  logic                        xOpCodeEnabled_i;
  logic [formatIndexRange-1:0] instructionFormat_i;
  logic [immWith-1:0]          imm_i;
  logic                        is64Bit_i;
  logic [regWidth-1:0]         reg1Address_i;
  logic [regWidth-1:0]         reg2Address_i;
  logic [regWidth-1:0]         reg3Address_i;
  logic                        operand1Enable_i;
  logic                        operand2Enable_i;
  logic                        operand3Enable_i;
  logic                        operand1Writeback_i;
  logic                        wbValid_i;
  logic [regWidth-1:0]         wbAddress_i;

  logic                        issueValid_o;
  logic [opcodeWidth-1:0]      opCode_o;
  logic [xOpCodeWidth-1:0]     xOpCode_o;
  logic                        xOpCodeEnabled_o;
  logic [formatIndexRange-1:0] instructionFormat_o;
  logic [immWith-1:0]          imm_o;
  logic                        is64Bit_o;
  logic [regWidth-1:0]         reg1Address_o;
  logic [regWidth-1:0]         reg2Address_o;
  logic [regWidth-1:0]         reg3Address_o;
  logic                        operand1Enable_o;
  logic                        operand2Enable_o;
  logic                        operand3Enable_o;
  logic                        operand1Writeback_o;
  logic [OccWidth-1:0]         occupancy_o;
  logic [stallCntWidth-1:0]    stallCount_o;

  modport master (
    output enable_i, flush_i, instValid_i, opCode_i, xOpCode_i, xOpCodeEnabled_i,
           instructionFormat_i, imm_i, is64Bit_i, reg1Address_i, reg2Address_i,
           reg3Address_i, operand1Enable_i, operand2Enable_i, operand3Enable_i,
           operand1Writeback_i, wbValid_i, wbAddress_i,
    input  instReady_o, issueValid_o, opCode_o, xOpCode_o, xOpCodeEnabled_o,
           instructionFormat_o, imm_o, is64Bit_o, reg1Address_o, reg2Address_o,
           reg3Address_o, operand1Enable_o, operand2Enable_o, operand3Enable_o,
           operand1Writeback_o, occupancy_o, stallCount_o
  );

  modport slave (
    input  enable_i, flush_i, instValid_i, opCode_i, xOpCode_i, xOpCodeEnabled_i,
           instructionFormat_i, imm_i, is64Bit_i, reg1Address_i, reg2Address_i,
           reg3Address_i, operand1Enable_i, operand2Enable_i, operand3Enable_i,
           operand1Writeback_i, wbValid_i, wbAddress_i,
    output instReady_o, issueValid_o, opCode_o, xOpCode_o, xOpCodeEnabled_o,
           instructionFormat_o, imm_o, is64Bit_o, reg1Address_o, reg2Address_o,
           reg3Address_o, operand1Enable_o, operand2Enable_o, operand3Enable_o,
           operand1Writeback_o, occupancy_o, stallCount_o
  );
endinterface

// File: rtl/fx_issue_scheduler.sv
// In-order FX issue scheduler: instruction FIFO plus per-GPR busy scoreboard.
// Optional FXSCHED_WB_BYPASS_EN lets a same-cycle writeback unblock the head entry.
module fx_issue_scheduler #(
  parameter int opcodeWidth      = 6,
  parameter int xOpCodeWidth     = 10,
  parameter int immWith          = 16,
  parameter int regWidth         = 5,
  parameter int numRegs          = 2**regWidth,
  parameter int formatIndexRange = 5,
  parameter int queueDepth       = 4,
  parameter int stallCntWidth    = 16
) (
  input logic              clock_i,
  input logic              reset_i,
  fx_issue_scheduler_if.slave bus
);
  localparam int PtrWidth = $clog2(queueDepth);
  localparam int OccWidth = PtrWidth + 1;

  typedef struct packed {
    logic [opcodeWidth-1:0]      op_code;
    logic [xOpCodeWidth-1:0]     x_op_code;
    logic                        x_op_code_en;
    logic [formatIndexRange-1:0] inst_format;
    logic [immWith-1:0]          imm;
    logic                        is_64bit;
    logic [regWidth-1:0]         reg1;
    logic [regWidth-1:0]         reg2;
    logic [regWidth-1:0]         reg3;
    logic                        op1_en;
    logic                        op2_en;
    logic                        op3_en;
    logic                        op1_wb;
  } entry_t;

  entry_t                     queue_q [queueDepth];
  entry_t                     in_entry;
  entry_t                     head_entry;
  entry_t                     out_q;
  logic [PtrWidth-1:0]        head_q, tail_q;
  logic [OccWidth-1:0]        occ_q;
  logic [numRegs-1:0]         busy_q, busy_eff;
  logic [stallCntWidth-1:0]   stall_q;
  logic                       issue_valid_q;
  logic                       ready, push, pop, hazard, not_empty;

  always_comb begin
    in_entry              = '0;
    in_entry.op_code      = bus.opCode_i;
    in_entry.x_op_code    = bus.xOpCode_i;
    in_entry.x_op_code_en = bus.xOpCodeEnabled_i;
    in_entry.inst_format  = bus.instructionFormat_i;
    in_entry.imm          = bus.imm_i;
    in_entry.is_64bit     = bus.is64Bit_i;
    in_entry.reg1         = bus.reg1Address_i;
    in_entry.reg2         = bus.reg2Address_i;
    in_entry.reg3         = bus.reg3Address_i;
    in_entry.op1_en       = bus.operand1Enable_i;
    in_entry.op2_en       = bus.operand2Enable_i;
    in_entry.op3_en       = bus.operand3Enable_i;
    in_entry.op1_wb       = bus.operand1Writeback_i;
  end

  assign head_entry = queue_q[head_q];
  assign not_empty  = (occ_q != '0);
  assign ready      = reset_i && (occ_q != OccWidth'(queueDepth));
  assign push       = bus.instValid_i && ready && !bus.flush_i;

  always_comb begin
    busy_eff = busy_q;
`ifdef FXSCHED_WB_BYPASS_EN
    if (bus.wbValid_i) busy_eff[bus.wbAddress_i] = 1'b0;
`endif
    hazard = (head_entry.op1_en && busy_eff[head_entry.reg1]) ||
             (head_entry.op2_en && busy_eff[head_entry.reg2]) ||
             (head_entry.op3_en && busy_eff[head_entry.reg3]) ||
             (head_entry.op1_wb && busy_eff[head_entry.reg1]);
  end

  assign pop = bus.enable_i && not_empty && !hazard && !bus.flush_i;

  // Payload storage needs no reset: pointers/occupancy define validity.
  always_ff @(posedge clock_i) begin
    if (push) queue_q[tail_q] <= in_entry;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
      busy_q        <= '0;
      stall_q       <= '0;
      issue_valid_q <= 1'b0;
      out_q         <= '0;
    end else begin
      if (bus.enable_i && not_empty && hazard && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (bus.flush_i) begin
        head_q        <= '0;
        tail_q        <= '0;
        occ_q         <= '0;
        busy_q        <= '0;
        issue_valid_q <= 1'b0;
      end else begin
        issue_valid_q <= pop;
        if (push) tail_q <= tail_q + 1'b1;
        if (pop) begin
          head_q <= head_q + 1'b1;
          out_q  <= head_entry;
        end
        if (push && !pop) occ_q <= occ_q + 1'b1;
        else if (pop && !push) occ_q <= occ_q - 1'b1;
        // Clear first so a same-cycle issue to the same register keeps it busy.
        if (bus.wbValid_i) busy_q[bus.wbAddress_i] <= 1'b0;
        if (pop && head_entry.op1_wb) busy_q[head_entry.reg1] <= 1'b1;
      end
    end
  end

  assign bus.instReady_o         = ready;
  assign bus.issueValid_o        = issue_valid_q;
  assign bus.opCode_o            = out_q.op_code;
  assign bus.xOpCode_o           = out_q.x_op_code;
  assign bus.xOpCodeEnabled_o    = out_q.x_op_code_en;
  assign bus.instructionFormat_o = out_q.inst_format;
  assign bus.imm_o               = out_q.imm;
  assign bus.is64Bit_o           = out_q.is_64bit;
  assign bus.reg1Address_o       = out_q.reg1;
  assign bus.reg2Address_o       = out_q.reg2;
  assign bus.reg3Address_o       = out_q.reg3;
  assign bus.operand1Enable_o    = out_q.op1_en;
  assign bus.operand2Enable_o    = out_q.op2_en;
  assign bus.operand3Enable_o    = out_q.op3_en;
  assign bus.operand1Writeback_o = out_q.op1_wb;
  assign bus.occupancy_o         = occ_q;
  assign bus.stallCount_o        = stall_q;
endmodule

// File: tb/tb_fx_issue_scheduler.sv
// Directed self-checking bench for fx_issue_scheduler (default build and FXSCHED_WB_BYPASS_EN).
module tb_fx_issue_scheduler;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_stall;

`ifdef FXSCHED_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  fx_issue_scheduler_if bus ();

  fx_issue_scheduler dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] r3, input logic e1, input logic e2,
                          input logic e3, input logic w1, input logic [15:0] imm);
    bus.instValid_i         = 1'b1;
    bus.opCode_i            = op;
    bus.xOpCode_i           = {4'h5, op};
    bus.xOpCodeEnabled_i    = op[0];
    bus.instructionFormat_i = op[4:0];
    bus.imm_i               = imm;
    bus.is64Bit_i           = r1[0];
    bus.reg1Address_i       = r1;
    bus.reg2Address_i       = r2;
    bus.reg3Address_i       = r3;
    bus.operand1Enable_i    = e1;
    bus.operand2Enable_i    = e2;
    bus.operand3Enable_i    = e3;
    bus.operand1Writeback_i = w1;
  endtask

  task automatic idle_inst();
    bus.instValid_i = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_stall = 0;
    rst_n     = 1'b0;
    bus.enable_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.wbValid_i   = 1'b0;
    bus.wbAddress_i = '0;
    set_inst(6'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    idle_inst();

    // reset state
    repeat (3) tick();
    check_eq("rst_issue_valid", bus.issueValid_o, 0);
    check_eq("rst_occupancy", bus.occupancy_o, 0);
    check_eq("rst_stall", bus.stallCount_o, 0);
    check_eq("rst_ready", bus.instReady_o, 0);
    check_eq("rst_payload", {bus.opCode_o, bus.reg1Address_o, bus.imm_o}, 0);
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_rst", bus.instReady_o, 1);

    // single add: r3 <- f(r4), accept at E, issue at E+1
    bus.enable_i = 1'b1;
    set_inst(6'h1f, 5'd3, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    tick();
    idle_inst();
    check_eq("add_not_yet", bus.issueValid_o, 0);
    check_eq("add_occ1", bus.occupancy_o, 1);
    tick();
    check_eq("add_issue", bus.issueValid_o, 1);
    check_eq("add_payload", {bus.opCode_o, bus.reg1Address_o, bus.reg2Address_o, bus.imm_o},
             {6'h1f, 5'd3, 5'd4, 16'h1234});
    check_eq("add_xop", {bus.xOpCode_o, bus.operand2Enable_o, bus.operand1Writeback_o},
             {10'h15f, 1'b1, 1'b1});
    check_eq("add_occ0", bus.occupancy_o, 0);
    tick();
    check_eq("add_strobe_1cyc", bus.issueValid_o, 0);

    // RAW on r5
    set_inst(6'h05, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
    tick();
    set_inst(6'h06, 5'd6, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0006);
    tick();
    idle_inst();
    check_eq("raw_first_issue", {bus.issueValid_o, bus.opCode_o}, {1'b1, 6'h05});
    tick();
    exp_stall = 1;
    check_eq("raw_held", bus.issueValid_o, 0);
    check_eq("raw_stall1", bus.stallCount_o, 64'(exp_stall));
    bus.wbValid_i   = 1'b1;
    bus.wbAddress_i = 5'd5;
    tick();
    bus.wbValid_i = 1'b0;
    if (Bypass) begin
      check_eq("raw_wb_edge_issue", {bus.issueValid_o, bus.opCode_o}, {1'b1, 6'h06});
    end else begin
      exp_stall = 2;
      check_eq("raw_wb_edge_held", bus.issueValid_o, 0);
    end
    check_eq("raw_stall2", bus.stallCount_o, 64'(exp_stall));
    tick();
    if (Bypass)
      check_eq("raw_after_bypass", bus.issueValid_o, 0);
    else
      check_eq("raw_late_issue", {bus.issueValid_o, bus.opCode_o, bus.reg1Address_o},
               {1'b1, 6'h06, 5'd6});
    check_eq("raw_stall_final", bus.stallCount_o, 64'(exp_stall));
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;

    // fill with issue disabled
    bus.enable_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_inst(6'(16 + i), 5'(10 + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'(i * 16'h0111));
      tick();
    end
    check_eq("fill_occ4", bus.occupancy_o, 4);
    check_eq("fill_ready0", bus.instReady_o, 0);
    set_inst(6'h14, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0444);
    tick();
    check_eq("fill_fifth_held", bus.occupancy_o, 4);
    check_eq("fill_no_issue", bus.issueValid_o, 0);
    bus.enable_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int exp_occ;
      tick();
      if (k == 1) idle_inst();
      exp_occ = (k <= 1) ? 3 : 4 - k;
      check_eq($sformatf("fill_issue%0d", k),
               {bus.issueValid_o, bus.opCode_o, bus.reg1Address_o, bus.imm_o},
               {1'b1, 6'(16 + k), 5'(10 + k), 16'(k * 16'h0111)});
      check_eq($sformatf("fill_occ%0d", k), bus.occupancy_o, 64'(exp_occ));
    end
    tick();
    check_eq("fill_drained", bus.issueValid_o, 0);
    check_eq("fill_no_stall", bus.stallCount_o, 64'(exp_stall));
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;

    // continuous stream across pointer wrap
    for (int i = 0; i < 10; i++) begin
      set_inst(6'(32 + i), 5'(i), 5'(i + 1), 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA000 + 16'(i));
      tick();
      if (i > 0)
        check_eq($sformatf("wrap_issue%0d", i - 1),
                 {bus.issueValid_o, bus.opCode_o, bus.reg2Address_o, bus.imm_o},
                 {1'b1, 6'(31 + i), 5'(i), 16'hA000 + 16'(i - 1)});
    end
    idle_inst();
    tick();
    check_eq("wrap_issue9", {bus.issueValid_o, bus.opCode_o, bus.imm_o}, {1'b1, 6'd41, 16'hA009});
    check_eq("wrap_occ0", bus.occupancy_o, 0);

    // flush with 3 queued and r7 busy
    set_inst(6'h30, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0030);
    tick();
    idle_inst();
    tick();
    check_eq("flush_r7_producer", {bus.issueValid_o, bus.opCode_o}, {1'b1, 6'h30});
    bus.enable_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_inst(6'(49 + j), 5'(20 + j), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      tick();
    end
    check_eq("flush_occ3", bus.occupancy_o, 3);
    bus.flush_i = 1'b1;
    set_inst(6'h35, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    bus.flush_i = 1'b0;
    idle_inst();
    check_eq("flush_occ0", bus.occupancy_o, 0);
    check_eq("flush_no_issue", bus.issueValid_o, 0);
    bus.enable_i = 1'b1;
    set_inst(6'h34, 5'd1, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0034);
    tick();
    idle_inst();
    check_eq("flush_reader_queued", {bus.issueValid_o, bus.occupancy_o}, {1'b1 ^ 1'b1, 3'd1});
    tick();
    check_eq("flush_reader_issue", {bus.issueValid_o, bus.opCode_o}, {1'b1, 6'h34});
    tick();
    check_eq("flush_nothing_left", bus.issueValid_o, 0);
    check_eq("flush_stall", bus.stallCount_o, 64'(exp_stall));

    // same-cycle issue setting r9 and writeback clearing r9
    set_inst(6'h40, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040);
    tick();
    bus.wbValid_i   = 1'b1;
    bus.wbAddress_i = 5'd9;
    set_inst(6'h41, 5'd2, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0041);
    tick();
    bus.wbValid_i = 1'b0;
    idle_inst();
    check_eq("r9_producer_issue", {bus.issueValid_o, bus.opCode_o}, {1'b1, 6'h40});
    repeat (2) begin
      tick();
      exp_stall++;
      check_eq("r9_busy_held", bus.issueValid_o, 0);
    end
    check_eq("r9_stall", bus.stallCount_o, 64'(exp_stall));
    bus.wbValid_i   = 1'b1;
    bus.wbAddress_i = 5'd9;
    tick();
    bus.wbValid_i = 1'b0;
    if (Bypass) begin
      check_eq("r9_bypass_issue", {bus.issueValid_o, bus.opCode_o}, {1'b1, 6'h41});
    end else begin
      exp_stall++;
      check_eq("r9_wb_edge_held", bus.issueValid_o, 0);
      tick();
      check_eq("r9_reader_issue", {bus.issueValid_o, bus.opCode_o}, {1'b1, 6'h41});
    end
    check_eq("r9_stall_final", bus.stallCount_o, 64'(exp_stall));

    // asynchronous reset mid-operation
    bus.enable_i = 1'b0;
    set_inst(6'h3a, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    tick();
    tick();
    idle_inst();
    check_eq("mid_occ2", bus.occupancy_o, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_occ", bus.occupancy_o, 0);
    check_eq("mid_rst_stall", bus.stallCount_o, 0);
    check_eq("mid_rst_ready", bus.instReady_o, 0);
    check_eq("mid_rst_payload", {bus.issueValid_o, bus.opCode_o}, 0);
    tick();
    rst_n = 1'b1;
    bus.enable_i = 1'b1;
    tick();
    check_eq("mid_rst_lost", {bus.issueValid_o, bus.occupancy_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
